gshare_fetch_pc: RTL and testbench
==================================

# gshare_fetch_pc

Fetch-stage next-PC generator for the Gshare pipeline; it sits directly upstream of the branch target buffer. Each cycle it presents the fetch PC and the gshare-hashed index to the BTB. It combines the BTB hit/target with its own 2-bit pattern history table (PHT) and a speculative global history register (GHR) to choose the next PC. It also resolves branches reported by EX: it recovers from mispredicts and produces the registered BTB/PHT update stream.

## Interface
- ENTRY_NUM, 256: PHT entries; must equal the downstream BTB ENTRY_NUM
- INDEX_BITS, $clog2(ENTRY_NUM): index width, also the GHR width
- RESET_PC, 32'h0000_0000: fetch PC after reset
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_stall  in  1  hold PC and GHR (IF/ID back-pressure)
- lookup_pc  out  32  current fetch PC (also the IMEM address)
- lookup_index  out  INDEX_BITS  lookup_pc[INDEX_BITS+1:2] ^ ghr
- btb_hit  in  1  from BTB, same cycle
- predicted_target  in  32  from BTB, same cycle
- f_pred_taken  out  1  prediction attached to the fetched instruction
- f_pred_target  out  32  predicted next PC (target or PC+4)
- f_ghr  out  INDEX_BITS  GHR snapshot used for this fetch
- ex_valid  in  1  EX holds a valid instruction
- ex_is_cond  in  1  conditional branch
- ex_is_jump  in  1  JAL/JALR
- ex_pc  in  32  PC of the EX instruction
- ex_actual_taken  in  1  resolved direction (1 for jumps)
- ex_actual_target  in  32  resolved target
- ex_pred_taken  in  1  piped-through f_pred_taken
- ex_pred_target  in  32  piped-through f_pred_target
- ex_ghr  in  INDEX_BITS  piped-through f_ghr
- flush  out  1  squash IF/ID; asserted combinationally on mispredict
- update_en  out  1  registered BTB write enable
- update_index  out  INDEX_BITS  registered BTB write index
- update_pc  out  32  registered BTB write PC
- update_target  out  32  registered BTB write target
- branch_cnt  out  32  resolved branches and jumps (wraps)
- mispredict_cnt  out  32  mispredicts (wraps)

## Operation
- Prediction: pred_taken = btb_hit & (ex_is_jump-agnostic) pht[lookup_index][1].
  - BTB hit with PHT MSB 1: f_pred_taken=1, f_pred_target=predicted_target.
  - Otherwise: f_pred_taken=0, f_pred_target=lookup_pc+4.
  - f_ghr equals the current ghr.
- Resolve: ex_br = ex_valid & (ex_is_cond | ex_is_jump).
- Mispredict = ex_br & ((ex_actual_taken != ex_pred_taken) | (ex_actual_taken & ex_actual_target != ex_pred_target)).
- Next PC priority:
  1. Mispredict: redirect to ex_actual_taken ? ex_actual_target : ex_pc+4.
  2. fetch_stall: hold.
  3. Otherwise: f_pred_target.
- GHR:
  - Mispredict: ghr <= {ex_ghr[INDEX_BITS-2:0], ex_actual_taken}.
  - Else, when not stalled and btb_hit: shift in f_pred_taken.
  - No shift on a BTB miss.
- PHT: ENTRY_NUM 2-bit saturating counters, reset to 2'b01.
  - Update only for ex_valid & ex_is_cond.
  - Update is registered one cycle: index ex_pc[INDEX_BITS+1:2]^ex_ghr; increment if taken, else decrement.
  - Counters saturate at 3 and 0.
- BTB update (registered one cycle after EX):
  - update_en = ex_br & ex_actual_taken.
  - update_index = ex_pc[INDEX_BITS+1:2]^ex_ghr, update_pc = ex_pc, update_target = ex_actual_target.
  - Update is issued whether or not the branch was mispredicted.
- Counters: branch_cnt increments on ex_br; mispredict_cnt increments on mispredict. Both wrap at 2^32.
- All arithmetic is 32-bit unsigned; PC+4 wraps at 2^32.

## Timing
- Reset (reset_n low, asynchronous):
  - lookup_pc=RESET_PC, ghr=0, all PHT entries=01.
  - update_en=0, update_index/pc/target=0, branch_cnt=0, mispredict_cnt=0.
  - flush=0 (no ex_valid is assumed during reset).
- Reset deasserted mid-operation: state resumes from reset values; an in-flight registered update is dropped.
- Lookup to prediction is 0 cycles (combinational through the BTB). The PC register updates on the next edge.
- Mispredict redirect: the new PC appears on lookup_pc the cycle after flush is asserted.
- Simultaneous mispredict and fetch_stall: the redirect wins and the stall is ignored for that cycle.
- Registered PHT/BTB write vs. same-cycle lookup of the same index: the lookup reads the old value (no bypass).
- Back-to-back resolves: one PHT and one BTB update per cycle, with no loss.

## Test plan
- Reset with RESET_PC=0x100 -> lookup_pc=0x100, update_en=0, counters 0. With no BTB hits, PC steps 0x104, 0x108.
- btb_hit=1, predicted_target=0x200, PHT entry=01 -> f_pred_taken=0, next PC=lookup_pc+4, GHR shifts in 0.
- Cond branch at 0x40 resolved taken to 0x80 with pred_taken=0, ex_ghr=0:
  - flush=1; lookup_pc=0x80 next cycle; GHR=1.
  - Next cycle: update_en=1, update_index=0x10, update_target=0x80; PHT[0x10] becomes 10.
  - mispredict_cnt=1.
- Four taken resolves on one index -> PHT saturates at 11. Five not-taken resolves -> saturates at 00.
- Mispredict and fetch_stall asserted together -> redirect taken. Stall alone -> lookup_pc and GHR held.
- Correctly predicted jump (pred_target == actual_target) -> flush=0, branch_cnt increments, mispredict_cnt unchanged, update_en=1.

Source files
------------

// File: rtl/gshare_fetch_pc.sv
// Fetch-stage next-PC generator: gshare-indexed PHT plus speculative GHR in front of the BTB,
// with EX-side mispredict recovery and a registered BTB/PHT update stream.
module gshare_fetch_pc #(
    parameter int          ENTRY_NUM  = 256,
    parameter int          INDEX_BITS = $clog2(ENTRY_NUM),
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_stall,
    output logic [31:0]           lookup_pc,
    output logic [INDEX_BITS-1:0] lookup_index,
    input  logic                  btb_hit,
    input  logic [31:0]           predicted_target,
    output logic                  f_pred_taken,
    output logic [31:0]           f_pred_target,
    output logic [INDEX_BITS-1:0] f_ghr,
    input  logic                  ex_valid,
    input  logic                  ex_is_cond,
    input  logic                  ex_is_jump,
    input  logic [31:0]           ex_pc,
    input  logic                  ex_actual_taken,
    input  logic [31:0]           ex_actual_target,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    input  logic [INDEX_BITS-1:0] ex_ghr,
    output logic                  flush,
    output logic                  update_en,
    output logic [INDEX_BITS-1:0] update_index,
    output logic [31:0]           update_pc,
    output logic [31:0]           update_target,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    logic [31:0]           pc_q;
    logic [INDEX_BITS-1:0] ghr_q;
    logic [1:0]            pht [ENTRY_NUM];

    logic                  ex_br;
    logic                  mispredict;
    logic [INDEX_BITS-1:0] ex_index;
    logic [31:0]           next_pc;
    logic [INDEX_BITS-1:0] next_ghr;

    logic                  pht_wr_en;
    logic [INDEX_BITS-1:0] pht_wr_index;
    logic                  pht_wr_taken;
    logic [1:0]            pht_wr_value;

    // Prediction path: purely combinational through the BTB.
    assign lookup_pc     = pc_q;
    assign lookup_index  = pc_q[INDEX_BITS+1:2] ^ ghr_q;
    assign f_pred_taken  = btb_hit & pht[lookup_index][1];
    assign f_pred_target = f_pred_taken ? predicted_target : pc_q + 32'd4;
    assign f_ghr         = ghr_q;

    assign ex_br      = ex_valid & (ex_is_cond | ex_is_jump);
    assign ex_index   = ex_pc[INDEX_BITS+1:2] ^ ex_ghr;
    assign mispredict = ex_br & ((ex_actual_taken != ex_pred_taken) |
                                 (ex_actual_taken & (ex_actual_target != ex_pred_target)));
    assign flush      = mispredict;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        next_pc  = pc_q;
        next_ghr = ghr_q;
        if (mispredict) begin
            next_pc  = ex_actual_taken ? ex_actual_target : ex_pc + 32'd4;
            next_ghr = {ex_ghr[INDEX_BITS-2:0], ex_actual_taken};
        end else if (!fetch_stall) begin
            next_pc = f_pred_target;
            if (btb_hit) next_ghr = {ghr_q[INDEX_BITS-2:0], f_pred_taken};
        end
    end

    always_comb begin
        pht_wr_value = pht[pht_wr_index];
        if (pht_wr_taken && pht_wr_value != 2'b11)
            pht_wr_value = pht_wr_value + 2'b01;
        else if (!pht_wr_taken && pht_wr_value != 2'b00)
            pht_wr_value = pht_wr_value - 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            ghr_q          <= '0;
            update_en      <= 1'b0;
            update_index   <= '0;
            update_pc      <= '0;
            update_target  <= '0;
            pht_wr_en      <= 1'b0;
            pht_wr_index   <= '0;
            pht_wr_taken   <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            pc_q         <= next_pc;
            ghr_q        <= next_ghr;
            update_en    <= ex_br & ex_actual_taken;
            pht_wr_en    <= ex_valid & ex_is_cond;
            pht_wr_index <= ex_index;
            pht_wr_taken <= ex_actual_taken;
            if (ex_br & ex_actual_taken) begin
                update_index  <= ex_index;
                update_pc     <= ex_pc;
                update_target <= ex_actual_target;
            end
            if (ex_br)      branch_cnt     <= branch_cnt + 32'd1;
            if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    // NOTE: the PHT must come out of reset weakly not-taken, so this array is reset explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) pht[i] <= 2'b01;
        end else if (pht_wr_en) begin
            pht[pht_wr_index] <= pht_wr_value;
        end
    end

endmodule

// File: tb/tb_gshare_fetch_pc.sv
// Directed self-checking bench for gshare_fetch_pc: prediction, redirect, GHR, PHT saturation,
// update stream, counters and reset behaviour.
module tb_gshare_fetch_pc;

    localparam int IB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fetch_stall;
    logic [31:0]   lookup_pc;
    logic [IB-1:0] lookup_index;
    logic          btb_hit;
    logic [31:0]   predicted_target;
    logic          f_pred_taken;
    logic [31:0]   f_pred_target;
    logic [IB-1:0] f_ghr;
    logic          ex_valid, ex_is_cond, ex_is_jump;
    logic [31:0]   ex_pc;
    logic          ex_actual_taken;
    logic [31:0]   ex_actual_target;
    logic          ex_pred_taken;
    logic [31:0]   ex_pred_target;
    logic [IB-1:0] ex_ghr;
    logic          flush, update_en;
    logic [IB-1:0] update_index;
    logic [31:0]   update_pc, update_target, branch_cnt, mispredict_cnt;

    int vectors = 0;
    int miscompares = 0;

    gshare_fetch_pc #(.ENTRY_NUM(256), .INDEX_BITS(IB), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_stall(fetch_stall),
        .lookup_pc(lookup_pc), .lookup_index(lookup_index),
        .btb_hit(btb_hit), .predicted_target(predicted_target),
        .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target), .f_ghr(f_ghr),
        .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
        .ex_actual_taken(ex_actual_taken), .ex_actual_target(ex_actual_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
        .flush(flush), .update_en(update_en), .update_index(update_index),
        .update_pc(update_pc), .update_target(update_target),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic cond, input logic jump, input logic [31:0] pc,
                            input logic taken, input logic [31:0] target,
                            input logic ptaken, input logic [31:0] ptarget, input logic [IB-1:0] ghr);
        ex_valid = 1'b1; ex_is_cond = cond; ex_is_jump = jump; ex_pc = pc;
        ex_actual_taken = taken; ex_actual_target = target;
        ex_pred_taken = ptaken; ex_pred_target = ptarget; ex_ghr = ghr;
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_is_cond = 1'b0; ex_is_jump = 1'b0; ex_pc = '0;
        ex_actual_taken = 1'b0; ex_actual_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0; ex_ghr = '0;
    endtask

    initial begin
        reset_n = 1'b0; fetch_stall = 1'b0; btb_hit = 1'b0; predicted_target = '0;
        clear_ex();
        #12;
        check("rst_pc", lookup_pc, 32'h100);
        check("rst_upd_en", {31'd0, update_en}, 32'd0);
        check("rst_br_cnt", branch_cnt, 32'd0);
        check("rst_mp_cnt", mispredict_cnt, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_ghr", {24'd0, f_ghr}, 32'd0);
        reset_n = 1'b1;

        // Sequential fetch with no BTB hits.
        check("seq_target", f_pred_target, 32'h104);
        step(); check("seq_pc1", lookup_pc, 32'h104);
        step(); check("seq_pc2", lookup_pc, 32'h108);
        check("seq_index", {24'd0, lookup_index}, 32'h42);

        // BTB hit on a weakly not-taken entry: fall through, shift in 0.
        btb_hit = 1'b1; predicted_target = 32'h200; #1;
        check("wnt_taken", {31'd0, f_pred_taken}, 32'd0);
        check("wnt_target", f_pred_target, 32'h10c);
        step(); check("wnt_pc", lookup_pc, 32'h10c);
        check("wnt_ghr", {24'd0, f_ghr}, 32'd0);

        // Cond branch at 0x40 taken to 0x80, predicted not-taken.
        btb_hit = 1'b0;
        drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 8'h00);
        check("mp1_flush", {31'd0, flush}, 32'd1);
        step();
        check("mp1_pc", lookup_pc, 32'h80);
        check("mp1_ghr", {24'd0, f_ghr}, 32'h1);
        check("mp1_upd_en", {31'd0, update_en}, 32'd1);
        check("mp1_upd_idx", {24'd0, update_index}, 32'h10);
        check("mp1_upd_pc", update_pc, 32'h40);
        check("mp1_upd_tgt", update_target, 32'h80);
        check("mp1_mp_cnt", mispredict_cnt, 32'd1);
        check("mp1_br_cnt", branch_cnt, 32'd1);

        // Jump mispredict with fetch_stall asserted: redirect wins; lands on index 0x10.
        fetch_stall = 1'b1; btb_hit = 1'b1;
        drive_ex(1'b0, 1'b1, 32'h300, 1'b1, 32'h44, 1'b0, 32'h304, 8'h00);
        check("mp2_flush", {31'd0, flush}, 32'd1);
        step();
        clear_ex(); #1;
        check("mp2_pc", lookup_pc, 32'h44);
        check("mp2_ghr", {24'd0, f_ghr}, 32'h1);
        check("mp2_index", {24'd0, lookup_index}, 32'h10);
        check("mp2_upd_idx", {24'd0, update_index}, 32'hc0);
        check("pht10_taken", {31'd0, f_pred_taken}, 32'd1);
        check("pht10_target", f_pred_target, 32'h200);

        // Saturation on index 0x10 while fetch is stalled.
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
            step();
        end
        check("sat_upd_en", {31'd0, update_en}, 32'd1);
        check("sat_upd_idx", {24'd0, update_index}, 32'h10);
        clear_ex(); step(); step();
        check("sat_hi_taken", {31'd0, f_pred_taken}, 32'd1);
        check("stall_pc", lookup_pc, 32'h44);
        drive_ex(1'b1, 1'b0, 32'h40, 1'b0, 32'h44, 1'b0, 32'h44, 8'h00);
        step(); clear_ex(); step(); step();
        check("sat_hi_dec", {31'd0, f_pred_taken}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive_ex(1'b1, 1'b0, 32'h40, 1'b0, 32'h44, 1'b0, 32'h44, 8'h00);
            step();
        end
        check("nt_upd_en", {31'd0, update_en}, 32'd0);
        clear_ex(); step(); step();
        check("sat_lo_taken", {31'd0, f_pred_taken}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 8'h00);
            step();
        end
        clear_ex(); step(); step();
        check("sat_lo_inc", {31'd0, f_pred_taken}, 32'd1);
        check("sat_br_cnt", branch_cnt, 32'd15);
        check("sat_mp_cnt", mispredict_cnt, 32'd2);

        // Not-taken mispredict under stall: redirect to ex_pc+4.
        drive_ex(1'b1, 1'b0, 32'h500, 1'b0, 32'h540, 1'b1, 32'h540, 8'h5a);
        check("mp3_flush", {31'd0, flush}, 32'd1);
        step(); clear_ex(); #1;
        check("mp3_pc", lookup_pc, 32'h504);
        check("mp3_ghr", {24'd0, f_ghr}, 32'hb4);
        check("mp3_mp_cnt", mispredict_cnt, 32'd3);
        check("mp3_upd_en", {31'd0, update_en}, 32'd0);
        step();
        check("hold_pc", lookup_pc, 32'h504);
        check("hold_ghr", {24'd0, f_ghr}, 32'hb4);

        // Correctly predicted jump.
        fetch_stall = 1'b0; btb_hit = 1'b0;
        drive_ex(1'b0, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 32'h700, 8'h03);
        check("jmp_flush", {31'd0, flush}, 32'd0);
        step(); clear_ex(); #1;
        check("jmp_br_cnt", branch_cnt, 32'd17);
        check("jmp_mp_cnt", mispredict_cnt, 32'd3);
        check("jmp_upd_en", {31'd0, update_en}, 32'd1);
        check("jmp_upd_idx", {24'd0, update_index}, 32'h83);
        check("jmp_upd_tgt", update_target, 32'h700);
        check("jmp_pc", lookup_pc, 32'h508);

        // GHR shifts on BTB hit, holds on miss.
        btb_hit = 1'b1; #1;
        check("ghr_index", {24'd0, lookup_index}, 32'hf6);
        check("ghr_pred", {31'd0, f_pred_taken}, 32'd0);
        step();
        check("ghr_shift", {24'd0, f_ghr}, 32'h68);
        check("ghr_pc", lookup_pc, 32'h50c);
        btb_hit = 1'b0;
        step();
        check("ghr_noshift", {24'd0, f_ghr}, 32'h68);
        check("ghr_pc2", lookup_pc, 32'h510);

        // PC+4 wraps at 2^32.
        drive_ex(1'b0, 1'b1, 32'h700, 1'b1, 32'hffff_fffc, 1'b0, 32'h704, 8'h00);
        step(); clear_ex(); #1;
        check("wrap_pc", lookup_pc, 32'hffff_fffc);
        check("wrap_target", f_pred_target, 32'h0);
        step();
        check("wrap_pc2", lookup_pc, 32'h0);

        // Reset mid-operation drops the in-flight update.
        drive_ex(1'b0, 1'b1, 32'h800, 1'b1, 32'h900, 1'b1, 32'h900, 8'h00);
        step();
        check("pre_rst_upd", {31'd0, update_en}, 32'd1);
        clear_ex();
        reset_n = 1'b0; #1;
        check("mid_rst_upd", {31'd0, update_en}, 32'd0);
        check("mid_rst_pc", lookup_pc, 32'h100);
        check("mid_rst_br", branch_cnt, 32'd0);
        check("mid_rst_ghr", {24'd0, f_ghr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_rst_pc", lookup_pc, 32'h104);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
